// File: rtl/stream_fifo_cfg.sv
// stream_fifo_cfg
//   Valid/ready stream FIFO with arbitrary depth, optional fall-through
//   bypass, occupancy count and programmable almost-full/almost-empty flags.
//   Single clock domain, asynchronous active-high reset.
//
// Ports
//   clk, rst        clock (rising edge) / async active-high reset
//   flush_i         synchronous flush, drops all stored entries
//   enq_vld_i       enqueue valid
//   enq_payload_i   enqueue data
//   enq_rdy_o       enqueue ready
//   deq_vld_o       dequeue valid
//   deq_payload_o   dequeue data (head entry or bypassed enqueue data)
//   deq_rdy_i       dequeue ready
//   count_o         number of stored entries, 0..Depth
//   almost_full_o   count_o >= AlmostFullThr
//   almost_empty_o  count_o <= AlmostEmptyThr
module stream_fifo_cfg #(
  parameter int unsigned Depth          = 8,
  parameter int unsigned WordWidth      = 64,
  parameter bit          FallThrough    = 1'b0,
  parameter int unsigned AlmostFullThr  = 6,
  parameter int unsigned AlmostEmptyThr = 1,
  localparam int unsigned CntW          = $clog2(Depth + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 enq_vld_i,
  input  logic [WordWidth-1:0] enq_payload_i,
  output logic                 enq_rdy_o,
  output logic                 deq_vld_o,
  output logic [WordWidth-1:0] deq_payload_o,
  input  logic                 deq_rdy_i,
  output logic [CntW-1:0]      count_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  if (Depth < 1) begin : g_bad_depth
    $error("stream_fifo_cfg: Depth must be >= 1");
  end
  if (AlmostFullThr < 1 || AlmostFullThr > Depth) begin : g_bad_afull
    $error("stream_fifo_cfg: AlmostFullThr must be in 1..Depth");
  end
  if (AlmostEmptyThr > Depth - 1) begin : g_bad_aempty
    $error("stream_fifo_cfg: AlmostEmptyThr must be in 0..Depth-1");
  end

  logic [WordWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      rd_ptr;
  logic [PtrW-1:0]      wr_ptr;
  logic [CntW-1:0]      count;

  logic bypass;
  logic enq_fire;
  logic deq_fire;
  logic wr_en;
  logic rd_en;

  // Bypass is only possible while nothing is stored, so ordering is preserved.
  assign bypass = FallThrough && (count == '0);

  always_comb begin
    enq_rdy_o     = !flush_i && (count < CntW'(Depth));
    deq_vld_o     = 1'b0;
    deq_payload_o = mem[rd_ptr];
    if (!flush_i) begin
      if (bypass) begin
        deq_vld_o     = enq_vld_i;
        deq_payload_o = enq_payload_i;
      end else begin
        deq_vld_o     = (count != '0);
      end
    end else if (bypass) begin
      deq_payload_o = enq_payload_i;
    end
  end

  assign enq_fire = enq_vld_i && enq_rdy_o;
  assign deq_fire = deq_vld_o && deq_rdy_i;

  // A bypassed transfer consumes the enqueue beat directly: no write, no read.
  assign wr_en = enq_fire && !(bypass && deq_fire);
  assign rd_en = deq_fire && !bypass;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= enq_payload_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (wr_en && !rd_en) begin
        count <= count + 1'b1;
      end else if (rd_en && !wr_en) begin
        count <= count - 1'b1;
      end
    end
  end

  // Flags depend on the count register only, so they never follow enq/deq inputs.
  assign count_o        = count;
  assign almost_full_o  = (count >= CntW'(AlmostFullThr));
  assign almost_empty_o = (count <= CntW'(AlmostEmptyThr));

endmodule

// File: tb/tb_stream_fifo_cfg.sv
// tb_stream_fifo_cfg
//   Bench for stream_fifo_cfg. Two instances (Depth=5, 16-bit words,
//   AlmostFullThr=4, AlmostEmptyThr=1), one without and one with fall-through,
//   share the same input stimulus. Each instance has its own expected-data
//   queue; a negedge monitor pops it on every dequeue handshake.
module tb_stream_fifo_cfg;

  localparam int unsigned DEPTH = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        enq_vld = 1'b0;
  logic [15:0] enq_pl = '0;
  logic        deq_rdy = 1'b0;

  logic        rdy0, vld0, af0, ae0;
  logic [15:0] pl0;
  logic [2:0]  cnt0;
  logic        rdy1, vld1, af1, ae1;
  logic [15:0] pl1;
  logic [2:0]  cnt1;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] exp0 [$];
  logic [15:0] exp1 [$];

  always #5 clk = ~clk;

  stream_fifo_cfg #(
    .Depth(5), .WordWidth(16), .FallThrough(1'b0),
    .AlmostFullThr(4), .AlmostEmptyThr(1)
  ) u_ft0 (
    .clk(clk), .rst(rst), .flush_i(flush),
    .enq_vld_i(enq_vld), .enq_payload_i(enq_pl), .enq_rdy_o(rdy0),
    .deq_vld_o(vld0), .deq_payload_o(pl0), .deq_rdy_i(deq_rdy),
    .count_o(cnt0), .almost_full_o(af0), .almost_empty_o(ae0)
  );

  stream_fifo_cfg #(
    .Depth(5), .WordWidth(16), .FallThrough(1'b1),
    .AlmostFullThr(4), .AlmostEmptyThr(1)
  ) u_ft1 (
    .clk(clk), .rst(rst), .flush_i(flush),
    .enq_vld_i(enq_vld), .enq_payload_i(enq_pl), .enq_rdy_o(rdy1),
    .deq_vld_o(vld1), .deq_payload_o(pl1), .deq_rdy_i(deq_rdy),
    .count_o(cnt1), .almost_full_o(af1), .almost_empty_o(ae1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Control outputs expected from the current number of stored entries.
  task automatic chk_ctrl(input string tag, input int sz, input bit ft,
                          input logic rdy, input logic vld, input logic [2:0] cnt,
                          input logic af, input logic ae);
    bit e_rdy, e_vld;
    e_rdy = !flush && (sz < DEPTH);
    e_vld = !flush && ((ft && sz == 0) ? enq_vld : (sz != 0));
    chk({tag, "_enq_rdy"}, 32'(rdy), 32'(e_rdy));
    chk({tag, "_deq_vld"}, 32'(vld), 32'(e_vld));
    chk({tag, "_count"},   32'(cnt), 32'(sz));
    chk({tag, "_afull"},   32'(af),  32'(sz >= 4));
    chk({tag, "_aempty"},  32'(ae),  32'(sz <= 1));
  endtask

  // One clock cycle: drive inputs, check control outputs, record accepted data.
  task automatic step(input bit ev, input logic [15:0] pl, input bit dr, input bit fl);
    @(posedge clk);
    #1;
    enq_vld = ev;
    enq_pl  = pl;
    deq_rdy = dr;
    flush   = fl;
    #1;
    chk_ctrl("ft0", exp0.size(), 1'b0, rdy0, vld0, cnt0, af0, ae0);
    chk_ctrl("ft1", exp1.size(), 1'b1, rdy1, vld1, cnt1, af1, ae1);
    if (fl) begin
      exp0.delete();
      exp1.delete();
    end else if (ev) begin
      if (exp0.size() < DEPTH) exp0.push_back(pl);
      if (exp1.size() < DEPTH) exp1.push_back(pl);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rst_rdy0"}, 32'(rdy0), 32'd1);
    chk({tag, "_rst_vld0"}, 32'(vld0), 32'd0);
    chk({tag, "_rst_cnt0"}, 32'(cnt0), 32'd0);
    chk({tag, "_rst_af0"},  32'(af0),  32'd0);
    chk({tag, "_rst_ae0"},  32'(ae0),  32'd1);
    chk({tag, "_rst_rdy1"}, 32'(rdy1), 32'd1);
    chk({tag, "_rst_cnt1"}, 32'(cnt1), 32'd0);
    chk({tag, "_rst_af1"},  32'(af1),  32'd0);
    chk({tag, "_rst_ae1"},  32'(ae1),  32'd1);
  endtask

  // Scoreboard monitor: every dequeue handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst) begin
      if (vld0 && deq_rdy) begin
        if (exp0.size() == 0) chk("ft0_unexpected_deq", 32'(pl0), 32'hFFFF_FFFF);
        else chk("ft0_deq_data", 32'(pl0), 32'(exp0.pop_front()));
      end
      if (vld1 && deq_rdy) begin
        if (exp1.size() == 0) chk("ft1_unexpected_deq", 32'(pl1), 32'hFFFF_FFFF);
        else chk("ft1_deq_data", 32'(pl1), 32'(exp1.pop_front()));
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk_reset_vals("init");
    chk("init_vld1", 32'(vld1), 32'd0);

    // Fill to full without dequeue, then one refused push
    for (int unsigned i = 0; i < 5; i++) step(1'b1, 16'(16'hA + i), 1'b0, 1'b0);
    step(1'b1, 16'hFF, 1'b0, 1'b0);
    chk("full_cnt0", 32'(cnt0), 32'd5);
    chk("full_rdy0", 32'(rdy0), 32'd0);
    chk("full_af0",  32'(af0),  32'd1);
    chk("full_cnt1", 32'(cnt1), 32'd5);
    chk("full_rdy1", 32'(rdy1), 32'd0);
    // Drain: monitor expects 0xA..0xE in order
    for (int unsigned i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("drained_cnt0", 32'(cnt0), 32'd0);

    // Wrap: steady count 3 with simultaneous enq+deq
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 16'(16'h10 + i), 1'b0, 1'b0);
    for (int unsigned i = 0; i < 20; i++) step(1'b1, 16'(16'h20 + i), 1'b1, 1'b0);
    chk("wrap_cnt0", 32'(cnt0), 32'd3);
    chk("wrap_cnt1", 32'(cnt1), 32'd3);
    for (int unsigned i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Fall-through on empty FIFO
    step(1'b1, 16'h55, 1'b1, 1'b0);
    chk("ft_same_cycle_vld1", 32'(vld1), 32'd1);
    chk("ft_same_cycle_pl1",  32'(pl1),  32'h55);
    chk("ft_same_cycle_vld0", 32'(vld0), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("ft_after_cnt1", 32'(cnt1), 32'd0);
    chk("ft_after_cnt0", 32'(cnt0), 32'd1);
    chk("ft_after_pl0",  32'(pl0),  32'h55);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush with count 3 and an enqueue attempt
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 16'(16'h30 + i), 1'b0, 1'b0);
    step(1'b1, 16'h99, 1'b1, 1'b1);
    chk("flush_rdy0", 32'(rdy0), 32'd0);
    chk("flush_vld0", 32'(vld0), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("postflush_cnt0", 32'(cnt0), 32'd0);
    chk("postflush_ae0",  32'(ae0),  32'd1);
    step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with count 4
    for (int unsigned i = 0; i < 4; i++) step(1'b1, 16'(16'h40 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("prerst_cnt0", 32'(cnt0), 32'd4);
    #1 rst = 1'b1;
    #1 chk_reset_vals("async");
    chk("async_vld0_idle", 32'(vld0), 32'd0);
    exp0.delete();
    exp1.delete();
    @(posedge clk);
    #1 rst = 1'b0;

    // Random traffic with occasional flush
    for (int unsigned i = 0; i < 2000; i++) begin
      step(($urandom_range(99) < 60), 16'($urandom), ($urandom_range(99) < 55),
           ($urandom_range(99) < 2));
    end
    for (int unsigned i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("final_empty0", 32'(exp0.size()), 32'(cnt0));
    chk("final_cnt0", 32'(cnt0), 32'd0);
    chk("final_cnt1", 32'(cnt1), 32'd0);

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
